muldiv_sequencer: RTL and testbench

//  Iterative multiply/divide unit beside the execute-stage ALU. Owns the HI/LO registers.

---
 rtl/muldiv_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// ----------------------------------------------------------------------------
// muldiv_sequencer
//   Iterative multiply/divide unit that sits beside the execute-stage ALU and
//   owns the HI/LO registers. A multiply runs as shift-add and a divide runs
//   as restoring division. Each runs one bit per clock, for WIDTH iterations.
//   The unit holds busy high so the pipeline stalls MULT/DIV/MFHI/MFLO until
//   the result is in HI/LO.
//
//   Optional feature macro: MULDIV_SIGNED_EN
//     defined   : op[1]=1 selects a signed operation. Operands are made
//                 absolute at start. A FIX cycle negates the results when
//                 needed (truncating division).
//     undefined : op[1] is ignored and every operation is unsigned. The
//                 abs/negate logic is not built.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high
//   start      in   1      request a new operation (sampled only in IDLE)
//   op         in   2      00 MULTU, 01 DIVU, 10 MULT, 11 DIV (op[0]=divide)
//   vs         in   WIDTH  multiplicand / dividend
//   vt         in   WIDTH  multiplier / divisor
//   hi_we      in   1      MTHI write enable (IDLE only)
//   lo_we      in   1      MTLO write enable (IDLE only)
//   wdata      in   WIDTH  MTHI/MTLO data
//   busy       out  1      operation in flight (registered, = state != IDLE)
//   done       out  1      one-cycle pulse after HI/LO take a new result
//   hi         out  WIDTH  HI register (remainder / upper product)
//   lo         out  WIDTH  LO register (quotient / lower product)
//   dbg_state  out  2      FSM state (0 IDLE, 1 RUN, 2 FIX)
//
// Handshake: start is a level request. It is accepted only on a rising edge
// where the FSM is IDLE. While busy=1 the requester must hold the instruction.
// A start that arrives while busy is dropped and is not queued.
// ----------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] vs,
    input  logic [WIDTH-1:0] vt,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;     // upper product / partial remainder
    logic [WIDTH-1:0] mq_q, mq_d;       // multiplier -> lower product / dividend -> quotient
    logic [WIDTH-1:0] md_q, md_d;       // multiplicand / divisor
    logic             div_q, div_d;
    logic             neg_main_q, neg_main_d;  // negate product or quotient
    logic             neg_rem_q, neg_rem_d;    // negate remainder
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // ------------------------------------------------------------------
    // One iteration of the datapath.
    // Multiply: add the multiplicand when the multiplier LSB is set, then
    // shift {acc,mq} right. The carry becomes the new acc MSB.
    // Divide: shift {acc,mq} left by one and trial-subtract the divisor.
    // Keep the difference only if it is non-negative (restoring division).
    // With a zero divisor every trial succeeds. The quotient becomes all
    // ones and the remainder becomes the dividend.
    // ------------------------------------------------------------------
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_acc, mul_mq;
    logic [WIDTH:0]   div_sh, div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] div_acc, div_mq;
    logic [WIDTH-1:0] step_acc, step_mq;
    logic             last_iter;

    assign mul_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, md_q} : {(WIDTH+1){1'b0}});
    assign mul_acc  = mul_sum[WIDTH:1];
    assign mul_mq   = {mul_sum[0], mq_q[WIDTH-1:1]};

    assign div_sh   = {acc_q, mq_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, md_q};
    assign div_ok   = ~div_diff[WIDTH];
    assign div_acc  = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    assign div_mq   = {mq_q[WIDTH-2:0], div_ok};

    assign step_acc  = div_q ? div_acc : mul_acc;
    assign step_mq   = div_q ? div_mq  : mul_mq;
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // ------------------------------------------------------------------
    // Operand conditioning and the final sign fix
    // ------------------------------------------------------------------
    logic             s_vs, s_vt;
    logic [WIDTH-1:0] abs_vs, abs_vt;
    logic             fix_needed;
    logic [WIDTH-1:0] fix_hi, fix_lo;

`ifdef MULDIV_SIGNED_EN
    logic [2*WIDTH-1:0] prod_neg;

    assign s_vs   = op[1] & vs[WIDTH-1];
    assign s_vt   = op[1] & vt[WIDTH-1];
    assign abs_vs = s_vs ? (~vs + WIDTH'(1)) : vs;
    assign abs_vt = s_vt ? (~vt + WIDTH'(1)) : vt;

    assign fix_needed = neg_main_q | (div_q & neg_rem_q);
    assign prod_neg   = ~{acc_q, mq_q} + (2*WIDTH)'(1);

    always_comb begin
        fix_hi = acc_q;
        fix_lo = mq_q;
        if (div_q) begin
            if (neg_main_q) fix_lo = ~mq_q + WIDTH'(1);
            if (neg_rem_q)  fix_hi = ~acc_q + WIDTH'(1);
        end else if (neg_main_q) begin
            fix_hi = prod_neg[2*WIDTH-1:WIDTH];
            fix_lo = prod_neg[WIDTH-1:0];
        end
    end
`else
    logic unused_signed;

    assign s_vs          = 1'b0;
    assign s_vt          = 1'b0;
    assign abs_vs        = vs;
    assign abs_vt        = vt;
    assign fix_needed    = 1'b0;
    assign fix_hi        = acc_q;
    assign fix_lo        = mq_q;
    assign unused_signed = ^{op[1], neg_main_q, neg_rem_q};
`endif

    // ------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mq_d       = mq_q;
        md_d       = md_q;
        div_d      = div_q;
        neg_main_d = neg_main_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // A start on the same edge as an MTHI/MTLO wins.
                    // The register write is dropped.
                    acc_d      = '0;
                    mq_d       = abs_vs;
                    md_d       = abs_vt;
                    div_d      = op[0];
                    neg_main_d = s_vs ^ s_vt;
                    neg_rem_d  = s_vs;
                    cnt_d      = '0;
                    state_d    = S_RUN;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_RUN: begin
                acc_d = step_acc;
                mq_d  = step_mq;
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    if (fix_needed) begin
                        state_d = S_FIX;
                    end else begin
                        hi_d    = step_acc;
                        lo_d    = step_mq;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_FIX: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mq_q       <= '0;
            md_q       <= '0;
            div_q      <= 1'b0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mq_q       <= mq_d;
            md_q       <= md_d;
            div_q      <= div_d;
            neg_main_q <= neg_main_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ----------------------------------------------------------------------------
// tb_muldiv_sequencer
//   Directed plus random stimulus for muldiv_sequencer. Expected {HI,LO}
//   results come from an arithmetic model. They are pushed onto exp_q when
//   an operation is started and popped when done pulses. Between results,
//   mdl_hi/mdl_lo track what HI/LO must hold.
// ----------------------------------------------------------------------------
module tb_muldiv_sequencer;

    localparam int W = 32;

`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] vs, vt, wdata;
    logic         hi_we, lo_we;
    logic         busy, done;
    logic [W-1:0] hi, lo;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .vs        (vs),
        .vt        (vt),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int             n_checks = 0;
    int             n_fail   = 0;
    logic [2*W-1:0] exp_q[$];
    logic [W-1:0]   mdl_hi, mdl_lo;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [2*W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic           sgn, sa, sb;
        logic [W-1:0]   ua, ub, q, r;
        logic [2*W-1:0] p;
        sgn = SIGNED_BUILD && o[1];
        sa  = sgn && a[W-1];
        sb  = sgn && b[W-1];
        ua  = sa ? -a : a;
        ub  = sb ? -b : b;
        if (o[0]) begin
            if (ub == '0) begin
                q = '1;
                r = ua;
            end else begin
                q = ua / ub;
                r = ua % ub;
            end
            if (sa ^ sb) q = -q;
            if (sa)      r = -r;
            return {r, q};
        end
        p = {{W{1'b0}}, ua} * {{W{1'b0}}, ub};
        if (sa ^ sb) p = -p;
        return p;
    endfunction

    function automatic int model_cycles(input logic [1:0] o, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
        logic sgn, sa, sb;
        sgn = SIGNED_BUILD && o[1];
        sa  = sgn && a[W-1];
        sb  = sgn && b[W-1];
        if (o[0]) return W + ((sa ^ sb) || sa ? 1 : 0);
        return W + ((sa ^ sb) ? 1 : 0);
    endfunction

    // ---------------- driver ----------------
    // Starts one operation. At loop cycle inject_at it drives a MULTU start
    // plus an MTHI write that must both be ignored. If lo_we_with_start is
    // set, an MTLO write is presented with the start; that write must be dropped.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inject_at, input bit lo_we_with_start, input string tag);
        logic [2*W-1:0] exp;
        int             cycles;
        int             exp_cycles;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        vs    = a;
        vt    = b;
        lo_we = lo_we_with_start;
        wdata = 32'hDEAD_BEEF;
        exp_q.push_back(model(o, a, b));
        exp_cycles = model_cycles(o, a, b);
        @(negedge clk);
        start  = 1'b0;
        lo_we  = 1'b0;
        cycles = 0;
        while (busy && cycles < 200) begin
            check({tag, " hold"}, {hi, lo}, {mdl_hi, mdl_lo});
            if (cycles == inject_at) begin
                start = 1'b1;
                op    = 2'b00;
                vs    = 32'd2;
                vt    = 32'd3;
                hi_we = 1'b1;
                wdata = 32'h0000_AAAA;
            end else begin
                start = 1'b0;
                hi_we = 1'b0;
            end
            cycles++;
            @(negedge clk);
        end
        start = 1'b0;
        hi_we = 1'b0;
        check({tag, " busy_cycles"}, 64'(cycles), 64'(exp_cycles));
        check({tag, " done"}, 64'(done), 64'd1);
        exp = exp_q.pop_front();
        check({tag, " result"}, {hi, lo}, exp);
        mdl_hi = exp[2*W-1:W];
        mdl_lo = exp[W-1:0];
        @(negedge clk);
        check({tag, " done_pulse"}, 64'(done), 64'd0);
        check({tag, " idle_after"}, 64'(busy), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        vs     = '0;
        vt     = '0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        wdata  = '0;
        mdl_hi = '0;
        mdl_lo = '0;

        repeat (3) @(negedge clk);
        check("reset busy",  64'(busy), 64'd0);
        check("reset done",  64'(done), 64'd0);
        check("reset hilo",  {hi, lo}, 64'd0);
        check("reset state", 64'(dbg_state), 64'd0);
        reset = 1'b0;

        // Full-scale unsigned multiply
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, "multu_max");
        check("multu_max const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        // Unsigned divide, including divide by zero
        run_op(2'b01, 32'd100, 32'd7, -1, 1'b0, "divu_100_7");
        check("divu_100_7 const", {hi, lo}, {32'd2, 32'd14});
        run_op(2'b01, 32'd5, 32'd0, -1, 1'b0, "divu_by0");
        check("divu_by0 const", {hi, lo}, {32'd5, 32'hFFFF_FFFF});

        // Start + MTHI while busy are ignored
        run_op(2'b01, 32'd1000, 32'd33, 5, 1'b0, "divu_inject");
        check("divu_inject const", {hi, lo}, {32'd10, 32'd30});

        // Reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        vs    = 32'd12345;
        vt    = 32'd678;
        exp_q.push_back(model(2'b00, 32'd12345, 32'd678));
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        mdl_hi = '0;
        mdl_lo = '0;
        check("abort busy",  64'(busy), 64'd0);
        check("abort done",  64'(done), 64'd0);
        check("abort hilo",  {hi, lo}, 64'd0);
        check("abort state", 64'(dbg_state), 64'd0);
        run_op(2'b00, 32'd6, 32'd7, -1, 1'b0, "mult_after_abort");
        check("mult_after_abort const", {hi, lo}, {32'd0, 32'd42});

        // MTHI alone, then MTHI+MTLO together
        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'h0000_1234;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi hi", 64'(hi), 64'h1234);
        check("mthi lo", 64'(lo), 64'(mdl_lo));
        mdl_hi = 32'h0000_1234;
        hi_we  = 1'b1;
        lo_we  = 1'b1;
        wdata  = 32'h0000_5555;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mthi_mtlo", {hi, lo}, {32'h5555, 32'h5555});
        mdl_hi = 32'h0000_5555;
        mdl_lo = 32'h0000_5555;

        // Start with MTLO in the same cycle; the MTLO is dropped
        run_op(2'b01, 32'd50, 32'd5, -1, 1'b1, "start_lo_we");
        check("start_lo_we const", {hi, lo}, {32'd0, 32'd10});

        // Signed operations (or their unsigned treatment)
`ifdef MULDIV_SIGNED_EN
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, -1, 1'b0, "div_m7_2");
        check("div_m7_2 const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op(2'b10, 32'hFFFF_FFFD, 32'd4, -1, 1'b0, "mult_m3_4");
        check("mult_m3_4 const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFF4});
`else
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, -1, 1'b0, "div_uns_fff9_2");
        check("div_uns_fff9_2 const", {hi, lo}, {32'd1, 32'h7FFF_FFFC});
`endif

        // Random mix of all opcodes
        for (int i = 0; i < 12; i++) begin
            logic [1:0]   r_op;
            logic [W-1:0] r_a, r_b;
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = (i % 4 == 3) ? 32'($urandom_range(1, 300)) : $urandom;
            run_op(r_op, r_a, r_b, -1, 1'b0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
